sprite_motion_ctrl: RTL and testbench
=====================================

// Module: sprite_motion_ctrl
// PURPOSE
//  Produces the sprite positions and Pac-Man facing that the display renderer consumes.
//  Once per video frame it moves Pac-Man in the last-requested direction, moves the ghost toward Pac-Man,
//  and detects capture. Sits between the button debouncers / vgac vertical sync and the display block.
// PARAMETERS
//  SPRITE     32   sprite edge in pixels; bounding box used for clamp and collision
//  H_ACTIVE   640  visible width; X range 0..H_ACTIVE-SPRITE (608)
//  V_ACTIVE   480  visible height; Y range 0..V_ACTIVE-SPRITE (448)
//  PAC_STEP   2    pixels per frame for Pac-Man
//  GHOST_STEP 1    pixels per ghost move
//  GHOST_DIV  2    ghost moves once every GHOST_DIV frame ticks (>=1)
//  PAC_X0/PAC_Y0      0/0      Pac-Man start position
//  GHOST_X0/GHOST_Y0  608/448  ghost start position
// PORTS
//  clk       in   1   system clock
//  clrn      in   1   asynchronous active-low reset
//  vs        in   1   vertical sync from vgac, active low; treated as asynchronous
//  btn       in   4   debounced levels {up,down,left,right}
//  start     in   1   level; starts or restarts a round
//  PacX      out  10  Pac-Man top-left X
//  PacY      out  9   Pac-Man top-left Y
//  state     out  2   facing: 00 up, 01 down, 10 right, 11 left
//  GhostX    out  10  ghost top-left X
//  GhostY    out  9   ghost top-left Y
//  game_over out  1   high while in CAUGHT
//  frame_tick out 1   one-clk pulse per frame
// BEHAVIOUR
//  Reset: Pac at PAC_X0/PAC_Y0; ghost at GHOST_X0/GHOST_Y0; state=10; game_over=0; frame_tick=0;
//   FSM=IDLE; ghost divider=0. Reset is asynchronous at any time, including mid-frame or mid-update.
//  Frame tick: vs passes a 2-flop synchroniser; a rising edge (end of sync pulse) gives frame_tick
//   in clock cycle T.
//  Direction latch: updated every clk from btn, in any FSM state. Priority up>down>left>right.
//   All buttons released -> hold the last direction. state = latched direction.
//  FSM:
//   IDLE  -- start=1 -> PLAY. Positions are reloaded to start values on entry.
//   PLAY  -- capture -> CAUGHT. start is ignored.
//   CAUGHT -- start=1 -> PLAY. Positions are reloaded to start values on entry.
//  PLAY update: applied at T+1, only when frame_tick fired at T.
//   Pac moves PAC_STEP along state. Result saturates at 0 or max, computed in 11 bits (no wrap).
//   Ghost divider counts ticks 0..GHOST_DIV-1. On terminal count the ghost moves GHOST_STEP
//    toward Pac along the axis with the larger |delta|; ties -> X axis.
//   If dx=dy=0 the ghost does not move. The ghost never overshoots: step = min(GHOST_STEP,|delta|).
//   Ghost position is clamped to range.
//   Deltas are signed 11-bit and use the pre-update positions.
//  Capture: |PacX-GhostX|<SPRITE && |PacY-GhostY|<SPRITE. Evaluated registered on the updated positions.
//   game_over rises at T+2. FSM leaves PLAY in the same cycle.
//   In CAUGHT and IDLE the positions are frozen; frame ticks only pulse frame_tick.
//  start held high across the transition: PLAY entered once; no re-entry while in PLAY.
//  Overlap at reset/start positions: capture is flagged on the first tick update.
// CONFIGURATION
//  PAC_WRAP_EN defined: Pac-Man wraps instead of saturating.
//   Moving past max -> 0; moving below 0 -> max. Example: X=608, right -> X=0.
//   The ghost always clamps.
//  PAC_WRAP_EN undefined: saturate as above.
// STRUCTURE
//  pacman_pkg holds:
//   - direction codes DIR_UP/DIR_DOWN/DIR_RIGHT/DIR_LEFT
//   - SCREEN_W/SCREEN_H and SPRITE_SZ constants
//   - FSM state encoding
//  One sub-module: frame_tick_gen (vs 2-flop sync + rising-edge pulse), reusable by other frame-rate blocks.
// TESTING
//  1 Reset with btn=0, start=0, 3 vs pulses -> positions 0,0 / 608,448; state=10; game_over=0; frame_tick pulses x3.
//  2 start=1, btn=right, 10 ticks -> PacX=20, PacY=0; ghost (GHOST_DIV=2) moved 5 steps toward Pac.
//  3 Pac at X=606 moving right, 2 ticks -> PacX=608 both ticks.
//     With PAC_WRAP_EN: tick1 -> 608, tick2 -> 0.
//  4 btn up+left pressed the same cycle -> state=00. Release all -> state stays 00.
//  5 Ghost placed 33 px right of Pac, same Y, Pac stationary at left wall -> on the capture frame
//     game_over=1 exactly T+2, positions frozen thereafter; start=1 -> reload to start values, game_over=0.
//  6 clrn pulsed low between frame_tick and the position update -> all outputs at reset values; no partial update.

Source files
------------

// File: rtl/pacman_pkg.sv
// Shared constants, direction codes and FSM encoding for the Pac-Man sprite blocks.
package pacman_pkg;

  localparam int SCREEN_W  = 640;
  localparam int SCREEN_H  = 480;
  localparam int SPRITE_SZ = 32;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_RIGHT = 2'b10,
    DIR_LEFT  = 2'b11
  } dir_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_PLAY   = 2'b01,
    ST_CAUGHT = 2'b10
  } fsm_e;

  // Operands are differences of 10-bit coordinates, so negation never overflows.
  function automatic logic [10:0] abs11(input logic signed [10:0] v);
    return v[10] ? $unsigned(-v) : $unsigned(v);
  endfunction

endpackage

// File: rtl/sprite_motion_ctrl_if.sv
// Input controls and sprite outputs of sprite_motion_ctrl, grouped for the display side.
interface sprite_motion_ctrl_if;
  import pacman_pkg::*;

  // No valid/ready handshake: all outputs are levels that change only in the
  // cycle after frame_tick (positions) or on any clock (facing); the renderer
  // may sample them at any time. btn and start are levels sampled every clock.
  logic [3:0] btn;
  logic       start;
  logic [9:0] PacX;
  logic [8:0] PacY;
  logic [1:0] state;
  logic [9:0] GhostX;
  logic [8:0] GhostY;
  logic       game_over;
  logic       frame_tick;
  fsm_e       fsm;

  modport master (
    input  btn, start,
    output PacX, PacY, state, GhostX, GhostY, game_over, frame_tick, fsm
  );

  modport slave (
    output btn, start,
    input  PacX, PacY, state, GhostX, GhostY, game_over, frame_tick, fsm
  );

endinterface

// File: rtl/frame_tick_gen.sv
// Synchronises the active-low vertical sync and pulses tick for one clock at
// the end of each sync pulse (rising edge of vs).
module frame_tick_gen (
  input  logic clk,
  input  logic rst_n,
  input  logic vs,
  output logic tick
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic s3_q, s3_d;
  logic tick_q, tick_d;

  always_comb begin
    s1_d   = vs;
    s2_d   = s1_q;
    s3_d   = s2_q;
    tick_d = s2_q & ~s3_q;
  end

  // Sync flops reset to the idle (high) level so release of reset is not seen as an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= 1'b1;
      s2_q   <= 1'b1;
      s3_q   <= 1'b1;
      tick_q <= 1'b0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      s3_q   <= s3_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/sprite_motion_ctrl.sv
// Sprite motion controller: per-frame Pac-Man/ghost movement and capture detection.
// Define PAC_WRAP_EN to make Pac-Man wrap at the screen edges instead of saturating.
module sprite_motion_ctrl
  import pacman_pkg::*;
#(
  parameter int SPRITE     = SPRITE_SZ,
  parameter int H_ACTIVE   = SCREEN_W,
  parameter int V_ACTIVE   = SCREEN_H,
  parameter int PAC_STEP   = 2,
  parameter int GHOST_STEP = 1,
  parameter int GHOST_DIV  = 2,
  parameter int PAC_X0     = 0,
  parameter int PAC_Y0     = 0,
  parameter int GHOST_X0   = H_ACTIVE - SPRITE,
  parameter int GHOST_Y0   = V_ACTIVE - SPRITE
) (
  input  logic                 clk,
  input  logic                 clrn,
  input  logic                 vs,
  sprite_motion_ctrl_if.master bus
);

  localparam logic [10:0] X_MAX = 11'(H_ACTIVE - SPRITE);
  localparam logic [10:0] Y_MAX = 11'(V_ACTIVE - SPRITE);
  localparam int DIV_W = (GHOST_DIV > 1) ? $clog2(GHOST_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(GHOST_DIV - 1);

  // One Pac-Man step in 12 bits; bit 11 flags a move below zero.
  function automatic logic [10:0] pac_move(input logic [10:0] pos, input logic [10:0] lim,
                                           input logic fwd);
    logic [11:0] r;
    r = fwd ? ({1'b0, pos} + 12'(PAC_STEP)) : ({1'b0, pos} - 12'(PAC_STEP));
`ifdef PAC_WRAP_EN
    if (r[11])           return lim;
    else if (r[10:0] > lim) return 11'd0;
    else                 return r[10:0];
`else
    if (r[11])           return 11'd0;
    else if (r[10:0] > lim) return lim;
    else                 return r[10:0];
`endif
  endfunction

  function automatic logic [10:0] ghost_move(input logic [10:0] pos, input logic neg,
                                             input logic [10:0] mag, input logic [10:0] lim);
    logic [10:0] step;
    logic [10:0] r;
    step = (mag < 11'(GHOST_STEP)) ? mag : 11'(GHOST_STEP);
    r    = neg ? (pos - step) : (pos + step);
    return (r > lim) ? lim : r;
  endfunction

  fsm_e             fsm_q, fsm_d;
  dir_e             dir_q, dir_d;
  logic [9:0]       pac_x_q, pac_x_d, ghost_x_q, ghost_x_d;
  logic [8:0]       pac_y_q, pac_y_d, ghost_y_q, ghost_y_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             chk_q, chk_d;

  logic             frame_tick;
  logic signed [10:0] dx, dy;
  logic [10:0]      adx, ady;
  logic             overlap;
  logic [9:0]       pac_x_mv, ghost_x_mv;
  logic [8:0]       pac_y_mv, ghost_y_mv;

  frame_tick_gen u_tick (
    .clk   (clk),
    .rst_n (clrn),
    .vs    (vs),
    .tick  (frame_tick)
  );

  always_comb begin
    dir_d = dir_q;
    if      (bus.btn[3]) dir_d = DIR_UP;
    else if (bus.btn[2]) dir_d = DIR_DOWN;
    else if (bus.btn[1]) dir_d = DIR_LEFT;
    else if (bus.btn[0]) dir_d = DIR_RIGHT;
  end

  // Deltas from the current registers: pre-update for the move, post-update for capture.
  always_comb begin
    dx      = $signed({1'b0, pac_x_q}) - $signed({1'b0, ghost_x_q});
    dy      = $signed({2'b0, pac_y_q}) - $signed({2'b0, ghost_y_q});
    adx     = abs11(dx);
    ady     = abs11(dy);
    overlap = (adx < 11'(SPRITE)) && (ady < 11'(SPRITE));
  end

  always_comb begin
    pac_x_mv   = pac_x_q;
    pac_y_mv   = pac_y_q;
    ghost_x_mv = ghost_x_q;
    ghost_y_mv = ghost_y_q;
    case (dir_q)
      DIR_UP:    pac_y_mv = 9'(pac_move({2'b0, pac_y_q}, Y_MAX, 1'b0));
      DIR_DOWN:  pac_y_mv = 9'(pac_move({2'b0, pac_y_q}, Y_MAX, 1'b1));
      DIR_RIGHT: pac_x_mv = 10'(pac_move({1'b0, pac_x_q}, X_MAX, 1'b1));
      default:   pac_x_mv = 10'(pac_move({1'b0, pac_x_q}, X_MAX, 1'b0));
    endcase
    if (adx >= ady) ghost_x_mv = 10'(ghost_move({1'b0, ghost_x_q}, dx[10], adx, X_MAX));
    else            ghost_y_mv = 9'(ghost_move({2'b0, ghost_y_q}, dy[10], ady, Y_MAX));
  end

  always_comb begin
    fsm_d     = fsm_q;
    pac_x_d   = pac_x_q;
    pac_y_d   = pac_y_q;
    ghost_x_d = ghost_x_q;
    ghost_y_d = ghost_y_q;
    div_d     = div_q;
    chk_d     = 1'b0;
    unique case (fsm_q)
      ST_IDLE, ST_CAUGHT: begin
        if (bus.start) begin
          fsm_d     = ST_PLAY;
          pac_x_d   = 10'(PAC_X0);
          pac_y_d   = 9'(PAC_Y0);
          ghost_x_d = 10'(GHOST_X0);
          ghost_y_d = 9'(GHOST_Y0);
          div_d     = '0;
        end
      end
      ST_PLAY: begin
        // chk_q marks the cycle right after an update, so capture is judged once per frame.
        if (chk_q && overlap) begin
          fsm_d = ST_CAUGHT;
        end else if (frame_tick) begin
          pac_x_d = pac_x_mv;
          pac_y_d = pac_y_mv;
          chk_d   = 1'b1;
          if (div_q == DIV_LAST) begin
            div_d     = '0;
            ghost_x_d = ghost_x_mv;
            ghost_y_d = ghost_y_mv;
          end else begin
            div_d = div_q + DIV_W'(1);
          end
        end
      end
      default: fsm_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      fsm_q     <= ST_IDLE;
      dir_q     <= DIR_RIGHT;
      pac_x_q   <= 10'(PAC_X0);
      pac_y_q   <= 9'(PAC_Y0);
      ghost_x_q <= 10'(GHOST_X0);
      ghost_y_q <= 9'(GHOST_Y0);
      div_q     <= '0;
      chk_q     <= 1'b0;
    end else begin
      fsm_q     <= fsm_d;
      dir_q     <= dir_d;
      pac_x_q   <= pac_x_d;
      pac_y_q   <= pac_y_d;
      ghost_x_q <= ghost_x_d;
      ghost_y_q <= ghost_y_d;
      div_q     <= div_d;
      chk_q     <= chk_d;
    end
  end

  assign bus.PacX       = pac_x_q;
  assign bus.PacY       = pac_y_q;
  assign bus.GhostX     = ghost_x_q;
  assign bus.GhostY     = ghost_y_q;
  assign bus.state      = dir_q;
  assign bus.game_over  = (fsm_q == ST_CAUGHT);
  assign bus.frame_tick = frame_tick;
  assign bus.fsm        = fsm_q;

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Directed bench for sprite_motion_ctrl: reset, motion, clamping, facing, capture and mid-update reset.
module tb_sprite_motion_ctrl;
  import pacman_pkg::*;

  logic clk;
  logic clrn;
  logic vs;
  int   total;
  int   bad;

  sprite_motion_ctrl_if bus ();

  sprite_motion_ctrl dut (
    .clk  (clk),
    .clrn (clrn),
    .vs   (vs),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_pos(input string tag, input int px, input int py, input int gx, input int gy);
    check({tag, "_pac_x"},   32'(bus.PacX),   32'(px));
    check({tag, "_pac_y"},   32'(bus.PacY),   32'(py));
    check({tag, "_ghost_x"}, 32'(bus.GhostX), 32'(gx));
    check({tag, "_ghost_y"}, 32'(bus.GhostY), 32'(gy));
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clrn      = 1'b0;
    vs        = 1'b1;
    bus.btn   = 4'b0000;
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #1 clrn = 1'b1;
    cyc();
  endtask

  // Pulses vs low then high; returns in the cycle where frame_tick is high.
  task automatic tick();
    bit seen;
    seen = 1'b0;
    vs = 1'b0;
    repeat (3) @(posedge clk);
    #1 vs = 1'b1;
    for (int i = 0; i < 8 && !seen; i++) begin
      cyc();
      if (bus.frame_tick === 1'b1) seen = 1'b1;
    end
    total++;
    assert (seen) else begin
      bad++;
      $error("FAIL frame_tick_seen: observed=0 expected=1");
    end
  endtask

  // Full frame: tick, update cycle, capture-evaluation cycle.
  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      cyc();
      cyc();
    end
  endtask

  initial begin
    int exp_wrap;
    total = 0;
    bad   = 0;
    clrn  = 1'b0;
    vs    = 1'b1;
    bus.btn   = 4'b0000;
    bus.start = 1'b0;
    do_reset();

    // 1: reset values, ticks in IDLE only pulse frame_tick
    check_pos("rst", 0, 0, 608, 448);
    check("rst_state", 32'(bus.state), 32'd2);
    check("rst_game_over", 32'(bus.game_over), 32'd0);
    check("rst_frame_tick", 32'(bus.frame_tick), 32'd0);
    check("rst_fsm", 32'(bus.fsm), 32'(ST_IDLE));
    for (int i = 0; i < 3; i++) begin
      tick();
      cyc();
      check("idle_tick_width", 32'(bus.frame_tick), 32'd0);
    end
    check_pos("idle_frozen", 0, 0, 608, 448);
    check("idle_fsm", 32'(bus.fsm), 32'(ST_IDLE));

    // 2: start held high, moving right, ghost every second tick
    bus.btn   = 4'b0001;
    bus.start = 1'b1;
    cyc();
    check("start_fsm", 32'(bus.fsm), 32'(ST_PLAY));
    run_ticks(1);
    check_pos("play_t1", 2, 0, 608, 448);
    run_ticks(1);
    check_pos("play_t2", 4, 0, 607, 448);
    run_ticks(8);
    check_pos("play_t10", 20, 0, 603, 448);
    check("play_t10_fsm", 32'(bus.fsm), 32'(ST_PLAY));
    bus.start = 1'b0;
    bus.btn   = 4'b0000;

    // 3: right-edge saturation (or wrap)
    run_ticks(293);
    check("edge_pre", 32'(bus.PacX), 32'd606);
    run_ticks(1);
    check("edge_t1", 32'(bus.PacX), 32'd608);
    run_ticks(1);
`ifdef PAC_WRAP_EN
    exp_wrap = 0;
`else
    exp_wrap = 608;
`endif
    check("edge_t2", 32'(bus.PacX), 32'(exp_wrap));
    check("edge_game_over", 32'(bus.game_over), 32'd0);

    // 4: facing priority and hold
    bus.btn = 4'b1010;
    cyc();
    check("dir_up_left", 32'(bus.state), 32'd0);
    bus.btn = 4'b0000;
    repeat (3) cyc();
    check("dir_hold_up", 32'(bus.state), 32'd0);
    bus.btn = 4'b0101;
    cyc();
    check("dir_down_right", 32'(bus.state), 32'd1);
    bus.btn = 4'b0011;
    cyc();
    check("dir_left_right", 32'(bus.state), 32'd3);
    bus.btn = 4'b0000;
    cyc();
    check("dir_hold_left", 32'(bus.state), 32'd3);

`ifndef PAC_WRAP_EN
    // 5: Pac parks at bottom-left corner, ghost walks in along the floor
    do_reset();
    bus.btn   = 4'b0100;
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    bus.btn   = 4'b0000;
    check("cap_start_fsm", 32'(bus.fsm), 32'(ST_PLAY));
    check("cap_start_dir", 32'(bus.state), 32'd1);
    run_ticks(224);
    check_pos("cap_corner", 0, 448, 496, 448);
    run_ticks(926);
    check_pos("cap_33px", 0, 448, 33, 448);
    check("cap_33px_go", 32'(bus.game_over), 32'd0);
    run_ticks(2);
    check_pos("cap_32px", 0, 448, 32, 448);
    check("cap_32px_go", 32'(bus.game_over), 32'd0);
    run_ticks(1);
    check("cap_32px_hold_go", 32'(bus.game_over), 32'd0);
    tick();
    check("cap_T_go", 32'(bus.game_over), 32'd0);
    cyc();
    check_pos("cap_T1", 0, 448, 31, 448);
    check("cap_T1_go", 32'(bus.game_over), 32'd0);
    check("cap_T1_fsm", 32'(bus.fsm), 32'(ST_PLAY));
    cyc();
    check("cap_T2_go", 32'(bus.game_over), 32'd1);
    check("cap_T2_fsm", 32'(bus.fsm), 32'(ST_CAUGHT));
    bus.btn = 4'b0001;
    run_ticks(3);
    check_pos("cap_frozen", 0, 448, 31, 448);
    check("cap_frozen_go", 32'(bus.game_over), 32'd1);
    bus.btn   = 4'b0000;
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    check_pos("cap_restart", 0, 0, 608, 448);
    check("cap_restart_go", 32'(bus.game_over), 32'd0);
    check("cap_restart_fsm", 32'(bus.fsm), 32'(ST_PLAY));
`endif

    // 6: reset asserted between frame_tick and the position update
    do_reset();
    bus.btn   = 4'b0001;
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    bus.btn   = 4'b0000;
    run_ticks(4);
    check_pos("mid_pre", 8, 0, 606, 448);
    bus.btn = 4'b0100;
    cyc();
    bus.btn = 4'b0000;
    check("mid_pre_dir", 32'(bus.state), 32'd1);
    tick();
    #1 clrn = 1'b0;
    #2;
    check_pos("mid_async", 0, 0, 608, 448);
    check("mid_async_state", 32'(bus.state), 32'd2);
    check("mid_async_tick", 32'(bus.frame_tick), 32'd0);
    check("mid_async_fsm", 32'(bus.fsm), 32'(ST_IDLE));
    cyc();
    clrn = 1'b1;
    repeat (3) cyc();
    check_pos("mid_after", 0, 0, 608, 448);
    check("mid_after_go", 32'(bus.game_over), 32'd0);
    check("mid_after_fsm", 32'(bus.fsm), 32'(ST_IDLE));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
